// File: rtl/ring_decoder.sv
// Decodes a one-hot ring pattern to a binary index, checking one-hot legality
// and rotation order, with a SEARCH/TRACK/LOCKED lock machine and error counter.
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int IDXW     = 2,
  parameter int LOCK_CNT = 2,
  parameter int ERRW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  ring_in,
  input  logic              clr_err,
  output logic [IDXW-1:0]   index,
  output logic              valid,
  output logic              onehot_err,
  output logic              seq_err,
  output logic              locked,
  output logic [ERRW-1:0]   err_count
);

  localparam int GOODW = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != {WIDTH{1'b0}}) && ((v & (v - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
  endfunction

  function automatic logic [IDXW-1:0] encode(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = {IDXW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        r = IDXW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [GOODW-1:0]   good_q, good_d;
  logic [IDXW-1:0]    index_q, index_d;
  logic               valid_q, valid_d;
  logic               oh_q, oh_d;
  logic               seq_q, seq_d;
  logic               locked_q, locked_d;
  logic [ERRW-1:0]    err_q, err_d;

  logic               legal_s;
  logic [IDXW-1:0]    idx_s;
  logic [IDXW-1:0]    exp_s;
  logic [GOODW-1:0]   good_inc_s;

  assign legal_s    = is_onehot(ring_in);
  assign idx_s      = encode(ring_in);
  // Ring shifts toward bit 0, so the next legal position is one lower, wrapping to the top.
  assign exp_s      = (index_q == {IDXW{1'b0}}) ? IDXW'(WIDTH - 1) : (index_q - {{(IDXW-1){1'b0}}, 1'b1});
  assign good_inc_s = good_q + {{(GOODW-1){1'b0}}, 1'b1};

  // Lock state machine, next index and error pulses.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    index_d = index_q;
    valid_d = 1'b0;
    oh_d    = 1'b0;
    seq_d   = 1'b0;
    if (en) begin
      case (state_q)
        SEARCH: begin
          if (legal_s) begin
            index_d = idx_s;
            valid_d = 1'b1;
            good_d  = {GOODW{1'b0}};
            state_d = TRACK;
          end else begin
            oh_d = 1'b1;
          end
        end
        TRACK, LOCKED: begin
          if (!legal_s) begin
            oh_d    = 1'b1;
            good_d  = {GOODW{1'b0}};
            state_d = SEARCH;
          end else if (idx_s == exp_s) begin
            index_d = idx_s;
            valid_d = 1'b1;
            if (state_q == TRACK) begin
              good_d  = good_inc_s;
              state_d = (good_inc_s == GOODW'(LOCK_CNT)) ? LOCKED : TRACK;
            end else begin
              state_d = LOCKED;
            end
          end else begin
            // Out-of-order sample becomes the new anchor.
            index_d = idx_s;
            valid_d = 1'b1;
            seq_d   = 1'b1;
            good_d  = {GOODW{1'b0}};
            state_d = TRACK;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = {GOODW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Lock level and saturating error counter, clear taking priority.
  always_comb begin
    locked_d = (state_d == LOCKED);
    if (clr_err) begin
      err_d = {ERRW{1'b0}};
    end else if ((oh_d || seq_d) && (err_q != {ERRW{1'b1}})) begin
      err_d = err_q + {{(ERRW-1){1'b0}}, 1'b1};
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      good_q   <= {GOODW{1'b0}};
      index_q  <= {IDXW{1'b0}};
      valid_q  <= 1'b0;
      oh_q     <= 1'b0;
      seq_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= {ERRW{1'b0}};
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
      oh_q     <= oh_d;
      seq_q    <= seq_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign index      = index_q;
  assign valid      = valid_q;
  assign onehot_err = oh_q;
  assign seq_err    = seq_q;
  assign locked     = locked_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder (WIDTH=4, LOCK_CNT=2, ERRW=2).
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ring_in;
  logic       clr_err;
  logic [1:0] index;
  logic       valid;
  logic       onehot_err;
  logic       seq_err;
  logic       locked;
  logic [1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  ring_decoder #(.WIDTH(4), .IDXW(2), .LOCK_CNT(2), .ERRW(2)) dut (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .clr_err(clr_err),
    .index(index), .valid(valid), .onehot_err(onehot_err), .seq_err(seq_err),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic c);
    en = e; ring_in = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // idx, valid, onehot_err, seq_err, locked, err_count
  task automatic chk_all(input string tag, input logic [1:0] i, input logic v,
                         input logic oh, input logic sq, input logic lk, input logic [1:0] ec);
    chk({tag, ".index"}, 32'(index), 32'(i));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".onehot_err"}, 32'(onehot_err), 32'(oh));
    chk({tag, ".seq_err"}, 32'(seq_err), 32'(sq));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ring_in = 4'b0000; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;

    // Lock-up
    step(1'b1, 4'b1000, 1'b0); chk_all("lock1", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b0100, 1'b0); chk_all("lock2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b0010, 1'b0); chk_all("lock3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b1, 4'b0001, 1'b0); chk_all("lock4", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);

    // Gaps with garbage on the bus, then wrap 0 -> 3
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0110, 1'b0); chk_all("gap", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    end
    step(1'b1, 4'b1000, 1'b0); chk_all("wrap", 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);

    // Illegal patterns
    step(1'b1, 4'b0110, 1'b0); chk_all("ill_two", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b1, 4'b0000, 1'b0); chk_all("ill_zero", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    step(1'b1, 4'b0001, 1'b0); chk_all("search_anchor", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 4'b1000, 1'b0); chk_all("relock1", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 4'b0100, 1'b0); chk_all("relock2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);

    // Sequence error while locked at 2
    step(1'b1, 4'b1000, 1'b0); chk_all("seq_err", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    step(1'b1, 4'b0100, 1'b0); chk_all("seq_rl1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    step(1'b1, 4'b0010, 1'b0); chk_all("seq_rl2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);

    // Clear, then saturate
    step(1'b0, 4'b0000, 1'b1); chk_all("clr", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b1, 4'b0000, 1'b0); chk_all("sat1", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b1, 4'b1111, 1'b0); chk_all("sat2", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    step(1'b1, 4'b0000, 1'b0); chk_all("sat3", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    step(1'b1, 4'b1010, 1'b0); chk_all("sat4", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    step(1'b1, 4'b0000, 1'b0); chk_all("sat5", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    step(1'b1, 4'b0000, 1'b1); chk_all("clr_wins", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // Wrap is one-directional: 0 followed by 1 is out of order
    step(1'b1, 4'b0001, 1'b0); chk_all("wr_anchor", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b0010, 1'b0); chk_all("wr_bad", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    step(1'b1, 4'b0001, 1'b0); chk_all("wr_rl1", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    step(1'b1, 4'b1000, 1'b0); chk_all("wr_rl2", 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);

    // Asynchronous reset while locked
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'b0010, 1'b0); chk_all("post_rst", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side counterpart to the team's one-hot ring counter. Samples a WIDTH-bit one-hot ring pattern and decodes it to a binary index. Checks each sample for one-hot legality and correct rotation order, and runs a lock state machine. Sits at the far end of a ring-counter bus, for example in a sequencer monitor, and reports position, lock status and error statistics.

## Interface
- WIDTH, 4: ring width in bits; must be ≥ 2.
- IDXW, 2: index width; must equal ceil(log2(WIDTH)).
- LOCK_CNT, 2: consecutive correct steps after the anchor sample that are required to declare lock; range 1..15.
- ERRW, 8: error counter width.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe; ring_in is evaluated only on cycles where en=1.
- ring_in  in  WIDTH  ring pattern to decode.
- clr_err  in  1  synchronous clear of err_count.
- index  out  IDXW  bit position of the single 1 in the last legal sample.
- valid  out  1  one-cycle pulse: index was updated from a legal sample.
- onehot_err  out  1  one-cycle pulse: sample was not one-hot (zero bits set, or two or more bits set).
- seq_err  out  1  one-cycle pulse: sample was one-hot but out of rotation order.
- locked  out  1  level: the decoder is in the LOCKED state.
- err_count  out  ERRW  saturating count of error pulses.

## Operation
- Rotation direction: the ring shifts toward bit 0 and wraps. Bit i takes bit i+1; bit WIDTH-1 takes bit 0. Example for WIDTH=4: 1000 → 0100 → 0010 → 0001 → 1000.
- Expected next index: exp = (prev == 0) ? WIDTH-1 : prev-1, where prev is the stored index.
- Legality check: a sample is legal when its popcount is exactly 1. For a legal sample, idx is the position of the set bit.
- State machine, three states, evaluated only when en=1:
  - SEARCH:
    - Legal sample → store idx, pulse valid, clear good_cnt, go to TRACK.
    - Illegal sample → pulse onehot_err, stay in SEARCH.
    - seq_err is never raised in SEARCH.
  - TRACK:
    - Legal sample with idx == exp → store idx, pulse valid, increment good_cnt. If good_cnt reaches LOCK_CNT, go to LOCKED.
    - Legal sample with idx != exp → store idx, pulse valid and seq_err, clear good_cnt, stay in TRACK. The new sample becomes the anchor.
    - Illegal sample → pulse onehot_err, clear good_cnt, go to SEARCH. index holds its old value.
  - LOCKED:
    - Legal sample in order → store idx, pulse valid, stay in LOCKED.
    - Legal sample out of order → store idx, pulse valid and seq_err, clear good_cnt, go to TRACK.
    - Illegal sample → pulse onehot_err, go to SEARCH.
- en=0: state, index, good_cnt and err_count hold; valid, onehot_err and seq_err are 0. A non-strobed cycle is not a rotation step.
- locked = (state == LOCKED), registered.
- err_count:
  - Increments by 1 on any cycle where onehot_err or seq_err is set. The two pulses are mutually exclusive.
  - Saturates at 2^ERRW − 1.
  - clr_err=1 forces err_count to 0 on the next edge. If clr_err coincides with an error, clear wins and the count is 0.

## Timing
- All outputs are registered. Latency is 1 cycle: a sample taken at edge N appears on index, valid, the error pulses, locked and err_count after edge N.
- Reset (asynchronous assert, synchronous deassert at the next edge):
  - index=0, valid=0, onehot_err=0, seq_err=0, locked=0, err_count=0.
  - state=SEARCH, good_cnt=0.
- Reset asserted mid-operation, including while LOCKED, clears everything immediately without waiting for a clock. The first strobed sample after release is treated as a fresh anchor.
- Lock time from reset: minimum 1 + LOCK_CNT strobed samples. locked rises 1 cycle after the LOCK_CNT-th in-order sample.
- Loss of lock: locked falls 1 cycle after the offending sample, together with that sample's error pulse.
- Wrap-around: index 0 followed by index WIDTH-1 is in order. index 0 followed by 1 is a seq_err.

## Test plan
- Lock-up, WIDTH=4, LOCK_CNT=2: after reset, strobe 1000, 0100, 0010, 0001 on consecutive cycles → index 3, 2, 1, 0 with valid each cycle; locked=1 one cycle after the 0010 sample; err_count=0.
- Wrap and gaps: while locked, strobe 0001, hold en=0 for 3 cycles, then strobe 1000 → no error pulses, locked stays 1, index goes 0 → 3.
- Illegal patterns: while locked, strobe 0110 → onehot_err pulse, locked=0, index held, err_count=1. Then strobe 0000 → a second onehot_err, err_count=2, state stays SEARCH.
- Sequence error: while locked at index 2, strobe 1000 → valid, seq_err, index=3, locked=0, state TRACK. Then strobe 0100 and 0010 → relock.
- Saturation and clear, ERRW=2: inject 5 illegal samples → err_count sticks at 3. Assert clr_err on the same cycle as a sixth error → err_count=0.
- Asynchronous reset while locked: assert rst between clock edges → all outputs 0 before the next edge. After release, the first strobe of 0010 → valid, index=1, locked=0.
